// File: rtl/modn_seq_checker_pkg.sv
// Shared types and constants for the mod-N sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modn_seq_checker_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Saturating increment for the error counter: sticks at ERR_CNT_MAX.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == ERR_CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/modn_inc.sv
// Modulo-N successor: y = x+1, or 0 when x = N-1.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module modn_inc #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  // Wrap at the modulus; the explicit compare keeps N = 2**W from overflowing.
  always_comb begin
    if (x == W'(N - 1)) y = '0;
    else                y = x + W'(1);
  end

endmodule

// File: rtl/modn_seq_checker.sv
// Locks onto a mod-N count stream and flags/counts samples that break the sequence.
// Latency: err/wrap/locked/exp_val/err_cnt are registered, one cycle after the sampling edge.
// Backpressure: none; ce only qualifies which edges sample cnt_in, the checker never stalls.
module modn_seq_checker
  import modn_seq_checker_pkg::*;
#(
  parameter int N        = 6,
  parameter int W        = 3,
  parameter int LOCK_CNT = 2,
  parameter int MISS_MAX = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [W-1:0]         cnt_in,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [W-1:0]         exp_val,
  output logic                 wrap
);

  state_t               state_q, state_d;
  logic [W-1:0]         exp_q, exp_d;
  logic [3:0]           good_q, good_d;
  logic [3:0]           miss_q, miss_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;
  logic                 err_q, err_d;
  logic                 wrap_q, wrap_d;
  logic                 locked_q, locked_d;

  logic [W-1:0] seed_nxt;
  logic [W-1:0] adv_nxt;
  logic [3:0]   good_inc;
  logic [3:0]   miss_inc;
  logic         valid;
  logic         match;

  // Successor of the observed sample, used when (re)seeding.
  modn_inc #(.N(N), .W(W)) u_inc_seed (
    .x (cnt_in),
    .y (seed_nxt)
  );

  // Successor of the current expectation, used on match and on freewheel.
  modn_inc #(.N(N), .W(W)) u_inc_adv (
    .x (exp_q),
    .y (adv_nxt)
  );

  assign valid    = (int'(cnt_in) < N);
  assign match    = valid && (cnt_in == exp_q);
  assign good_inc = good_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;

  // Next-state and next-output logic for the hunt/confirm/locked FSM.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    good_d  = good_q;
    miss_d  = miss_q;
    errc_d  = errc_q;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (ce) begin
      case (state_q)
        HUNT: begin
          if (valid) begin
            exp_d   = seed_nxt;
            good_d  = '0;
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (match) begin
            exp_d  = adv_nxt;
            good_d = good_inc;
            if (good_inc == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (valid) begin
            exp_d  = seed_nxt;
            good_d = '0;
          end else begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          // Expectation always advances: on a miss the checker freewheels.
          exp_d = adv_nxt;
          if (match) begin
            miss_d = '0;
            wrap_d = (cnt_in == W'(N - 1));
          end else begin
            err_d  = 1'b1;
            errc_d = sat_inc(errc_q);
            miss_d = miss_inc;
            if (miss_inc == 4'(MISS_MAX)) state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // Clear is a direct command on the counter and beats a same-edge error.
    if (clr) errc_d = '0;
    locked_d = (state_d == LOCKED);
  end

  // State and registered outputs; reset aborts any sequence in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      errc_q   <= '0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      errc_q   <= errc_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      locked_q <= locked_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign wrap    = wrap_q;
  assign err_cnt = errc_q;
  assign exp_val = exp_q;

endmodule
